uart_rx_axis_fifo: RTL
======================

Name: uart_rx_axis_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver block. That receiver emits bytes on a valid-only AXI-Stream (tdata, tuser = parity error, tvalid, no tready). This block accepts every strobe without back-pressure and stores it in a first-word-fall-through FIFO. It presents the stored bytes on a standard AXI-Stream master with tready. Error and overflow events are counted for software/status visibility.

Parameters:
DEPTH, 16, total byte capacity including output register; power of 2, >= 2
DROP_ERRORS, 1, 1 = discard bytes received with s_tuser=1; 0 = store them and forward the flag on m_tuser

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  asynchronous active-low reset
s_tdata  input  8  received byte from UART RX stage
s_tuser  input  1  parity error flag for s_tdata
s_tvalid  input  1  single-cycle strobe, one byte; no ready returned
m_tdata  output  8  output byte
m_tuser  output  1  parity-error flag of output byte (always 0 when DROP_ERRORS=1)
m_tvalid  output  1  output byte valid
m_tready  input  1  downstream ready
level  output  $clog2(DEPTH)+1  number of bytes held, 0..DEPTH
overflow_cnt  output  16  bytes lost because FIFO full, saturating
err_cnt  output  16  bytes received with s_tuser=1, saturating

Behaviour:
- Reset (aresetn low, asynchronous assert, synchronous release): m_tvalid=0, m_tdata=0, m_tuser=0, level=0, overflow_cnt=0, err_cnt=0, pointers=0. Memory contents are not reset. Reset mid-transfer discards all stored data and clears the counters.
- Handshake out: transfer occurs on an edge where m_tvalid && m_tready. While m_tvalid=1 && m_tready=0, m_tdata/m_tuser hold stable. m_tvalid = (level != 0).
- Registered output stage, FWFT: a byte written while level=0 appears on m_tvalid/m_tdata immediately after that same edge (1-edge latency). With no read, subsequent bytes queue in order.
- Write qualification per edge: wr_req = s_tvalid && !(s_tuser && DROP_ERRORS). rd = m_tvalid && m_tready.
- Full (level==DEPTH):
  - wr_req with rd on the same edge: the write is accepted and level is unchanged.
  - wr_req without rd: the byte is dropped, overflow_cnt increments, and stored data is unchanged.
- Empty (level==0): rd cannot occur. A write goes straight into the output register.
- Simultaneous wr and rd with 0<level<DEPTH: level unchanged. The output register loads the next queued byte, or the new byte when level==1.
- level: +1 on accepted write only, -1 on read only, otherwise unchanged. Never exceeds DEPTH or goes below 0.
- err_cnt increments on every s_tvalid && s_tuser, independent of DROP_ERRORS and of whether the byte was stored.
- A byte with s_tuser=1 dropped because DROP_ERRORS=1 is counted in err_cnt only, never in overflow_cnt. With DROP_ERRORS=0, a full FIFO on an error byte increments both counters.
- Counters saturate at 16'hFFFF; no wrap.
- Pointers wrap modulo DEPTH. Order is preserved across wrap.
- Storage: DEPTH-1 entry RAM plus one output register, or an equivalent arrangement. The externally visible capacity is exactly DEPTH.

Test Plan:
- Single byte: level=0, s_tvalid pulse s_tdata=0x55 s_tuser=0, m_tready=0 -> next cycle m_tvalid=1, m_tdata=0x55, level=1. Holds stable for 5 cycles. Raise m_tready -> one transfer, then m_tvalid=0, level=0.
- Fill/overflow, DEPTH=16: write 0x00..0x11 (18 bytes) with m_tready=0 -> level=16, overflow_cnt=2. Drain with m_tready=1 -> outputs 0x00..0x0F in order, then m_tvalid=0.
- Full with simultaneous read: level=16, s_tvalid with 0xA5 on the same edge as a read -> level stays 16, overflow_cnt unchanged, 0xA5 emerges last.
- Error handling: DROP_ERRORS=1, bytes 0x10(tuser=0), 0x20(tuser=1), 0x30(tuser=0) -> output 0x10, 0x30, err_cnt=1. DROP_ERRORS=0, same stimulus -> 0x10/0x20/0x30 with m_tuser=0/1/0, err_cnt=1.
- Wrap-around: 40 bytes 0..39 with m_tready toggling 1/0 every cycle, s_tvalid every 3rd cycle -> all 40 bytes output in order, overflow_cnt=0, final level=0.
- Reset mid-operation: level=7, assert aresetn low asynchronously between edges -> m_tvalid, level and counters go to 0 without a clock edge. After release, a new byte 0x3C is output first.

Source files
------------

// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo: buffers a valid-only UART RX byte stream into a
// first-word-fall-through FIFO and presents it as an AXI-Stream master.
// Parity-error and overflow events go to saturating 16-bit counters.
module uart_rx_axis_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter bit          DROP_ERRORS = 1'b1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [7:0]                 s_tdata,
    input  logic                       s_tuser,
    input  logic                       s_tvalid,
    output logic [7:0]                 m_tdata,
    output logic                       m_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                overflow_cnt,
    output logic [15:0]                err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Queue behind the output register; it never holds more than DEPTH-1
    // bytes, but sizing it to DEPTH keeps pointer wrap a plain overflow.
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    logic          wr_req;
    logic          rd;
    logic          full;
    logic          wr_acc;
    logic          out_from_ram;
    logic          out_from_in;
    logic          ram_wr;
    logic          err_evt;
    logic          ovf_evt;
    logic [LW-1:0] level_nxt;

    // Write/read qualification and output-register load selection.
    always_comb begin
        wr_req       = s_tvalid && !(s_tuser && DROP_ERRORS);
        rd           = m_tvalid && m_tready;
        full         = (level == LW'(DEPTH));
        wr_acc       = wr_req && (!full || rd);
        // Output register refills from the queue whenever it holds anything.
        out_from_ram = rd && (level > LW'(1));
        // New byte bypasses the queue when the output register would be empty.
        out_from_in  = wr_acc && (!m_tvalid || (rd && (level == LW'(1))));
        ram_wr       = wr_acc && !out_from_in;
        err_evt      = s_tvalid && s_tuser;
        ovf_evt      = wr_req && full && !rd;
        level_nxt    = level;
        if (wr_acc && !rd) begin
            level_nxt = level + LW'(1);
        end else if (!wr_acc && rd) begin
            level_nxt = level - LW'(1);
        end
    end

    // Queue storage; contents are intentionally not reset.
    always_ff @(posedge aclk) begin
        if (ram_wr) begin
            mem[wptr] <= {s_tuser, s_tdata};
        end
    end

    // Pointers, level and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 1'b0;
        end else begin
            level    <= level_nxt;
            m_tvalid <= (level_nxt != '0);
            if (ram_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (out_from_ram) begin
                rptr    <= rptr + AW'(1);
                m_tdata <= mem[rptr][7:0];
                m_tuser <= mem[rptr][8];
            end else if (out_from_in) begin
                m_tdata <= s_tdata;
                m_tuser <= s_tuser;
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt      <= '0;
            overflow_cnt <= '0;
        end else begin
            if (err_evt && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (ovf_evt && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

endmodule
